router_sa_scheduler: RTL and testbench
======================================

// Module: router_sa_scheduler
// PURPOSE
// Sequential switch allocator for a router's shared output toward the PE array. It arbitrates the four
// mesh input ports (NW=0, NE=1, SE=2, SW=3) and normally grants the lowest-address requester.
// It gates every grant on downstream credits and applies aging so no port starves.
// It also sequences the 4-way UV-merge transfer. The local port is not handled here; it keeps its always-grant path.
// PARAMETERS
// ADDR_WIDTH    8    width of each port's destination address
// RANK_WIDTH    4    low address bits forming the rank field compared for UV merge
// CREDIT_DEPTH  4    downstream buffer slots; credit counter reset value and maximum
// STARVE_LIMIT  15   wait cycles after which a requester becomes starved
// UV_TIMEOUT    255  maximum cycles spent in UV_GATHER before abort
// PORTS
// clk           in   1               clock, all state on rising edge
// rst           in   1               asynchronous, active-high reset
// sa_request    in   4               per-port request, bit index = direction
// sa_addr       in   4*ADDR_WIDTH    packed addresses, port d at [d*ADDR_WIDTH +: ADDR_WIDTH]
// sa_uv         in   4               per-port "flit is UV-merge" flag, valid with sa_request
// credit_in     in   1               one downstream slot freed this cycle
// sa_grant      out  4               registered grant, one-cycle pulse per winning port
// credit_count  out  $clog2(CREDIT_DEPTH+1)  current available credits
// uv_busy       out  1               high while state is UV_GATHER
// credit_err    out  1               sticky: credit_in received while counter already full
// uv_timeout    out  1               sticky: UV_GATHER aborted by timeout
// BEHAVIOUR
// Reset: state=ARB, sa_grant=0, credit_count=CREDIT_DEPTH, wait counters=0, uv_busy=0, credit_err=0, uv_timeout=0.
// Reset mid-transfer discards everything; there is no partial grant after rst deasserts.
// Latency: a request sampled in cycle t yields sa_grant in cycle t+1. Eligible = sa_request & ~sa_grant.
// So a port already granted this cycle is masked, and each port wins at most once per two cycles.
// Handshake: a requester keeps sa_request, sa_addr and sa_uv stable until it sees its grant bit.
// Credits: every cycle with sa_grant!=0 consumes exactly one credit; a UV 4'b1111 grant is one merged flit.
// Credits: credit_in adds one. Consume and return in the same cycle leave the count unchanged.
// Credits: a return while the count is full saturates the count and sets credit_err.
// No grant is issued while credit_count==0. Requests stay pending and keep aging.
// Aging: each port has a wait counter, saturating at STARVE_LIMIT.
// Aging: it increments on cycles where the port is eligible and not granted, and clears on grant or when the request drops.
// State ARB: if any eligible port has sa_uv=1, go to UV_GATHER, issue no grant this cycle, and clear the UV wait counter.
// State ARB: otherwise, if credit>0, grant exactly one port:
// State ARB: (a) any starved port (wait==STARVE_LIMIT): grant the lowest-index starved port;
// State ARB: (b) otherwise the eligible port with the smallest unsigned sa_addr; on an address tie the lower index wins.
// State UV_GATHER: no single-port grants.
// State UV_GATHER: when sa_request==4'b1111, sa_uv==4'b1111, all four rank fields (addr[RANK_WIDTH-1:0]) are equal and credit>0:
// State UV_GATHER: assert sa_grant=4'b1111 for one cycle and go to ARB.
// State UV_GATHER: if the UV wait counter reaches UV_TIMEOUT, set uv_timeout and return to ARB with no grant.
// State UV_GATHER: ARB then serves ports normally, even with uv=1, for exactly one arbitration win before re-entering UV_GATHER. This prevents livelock.
// State UV_GATHER: wait counters keep aging, but aging never breaks a UV gather.
// Simultaneous: if credit_in arrives while credit_count==0, a grant can issue next cycle, not the same cycle.
// TESTING
// T1 reset: assert rst asynchronously mid-cycle -> sa_grant=0, credit_count=4, flags=0, with no clock edge needed.
// T2 lowest address: req=4'b1111, addrs NW=9 NE=3 SE=3 SW=7 -> grants in order NE (0010), then SE, SW, NW; one per two cycles per port.
// T3 credits: no credit_in, 6 single requests -> exactly 4 grants, credit_count=0.
// T3 credits (cont.): then one credit_in pulse -> one more grant two cycles later.
// T3 credits (cont.): credit_in at count 4 -> credit_err=1 and count stays 4.
// T4 starvation: NW addr=200 held while NE/SE/SW keep re-requesting with addr<200 -> NW granted within STARVE_LIMIT+2 cycles.
// T5 UV merge: ports arrive with uv=1 and rank 5 on cycles 0, 3, 4, 8 -> uv_busy from cycle 1; sa_grant=4'b1111 once on cycle 9; one credit consumed.
// T6 UV abort: only 3 UV requesters -> uv_timeout=1 after 255 cycles, return to ARB, one normal grant issues; then re-enter UV_GATHER.

Source files
------------

// File: rtl/router_sa_scheduler.sv
// Switch allocator for the router's shared output toward the PE array.
// Arbitrates the four mesh ports (NW=0, NE=1, SE=2, SW=3). The lowest address
// wins unless a port is starved, and every grant is gated on downstream credits.
// The block also sequences the 4-way UV-merge gather, with a timeout and a
// one-win escape that prevents livelock.
module router_sa_scheduler #(
  parameter int ADDR_WIDTH   = 8,
  parameter int RANK_WIDTH   = 4,
  parameter int CREDIT_DEPTH = 4,
  parameter int STARVE_LIMIT = 15,
  parameter int UV_TIMEOUT   = 255
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [3:0]                         sa_request,
  input  logic [4*ADDR_WIDTH-1:0]            sa_addr,
  input  logic [3:0]                         sa_uv,
  input  logic                               credit_in,
  output logic [3:0]                         sa_grant,
  output logic [$clog2(CREDIT_DEPTH+1)-1:0]  credit_count,
  output logic                               uv_busy,
  output logic                               credit_err,
  output logic                               uv_timeout
);

  localparam int CW = $clog2(CREDIT_DEPTH + 1);
  localparam int WW = $clog2(STARVE_LIMIT + 1);
  localparam int UW = $clog2(UV_TIMEOUT + 1);

  typedef enum logic {ARB, UV_GATHER} state_e;

  state_e          state_q, state_d;
  logic [3:0]      grant_q, grant_d;
  logic [CW-1:0]   credit_q, credit_d;
  logic [WW-1:0]   wait_q [4];
  logic [WW-1:0]   wait_d [4];
  logic [UW-1:0]   uv_cnt_q, uv_cnt_d;
  logic            uv_pass_q, uv_pass_d;
  logic            credit_err_q, credit_err_d;
  logic            uv_timeout_q, uv_timeout_d;

  logic [3:0]            elig;
  logic [3:0]            starved;
  logic [1:0]            win_idx;
  logic [ADDR_WIDTH-1:0] best_addr;
  logic                  found;
  logic                  rank_eq;

  // A port granted last cycle is masked so it cannot win twice in a row.
  assign elig = sa_request & ~grant_q;

  // All four rank fields must match for a UV merge.
  assign rank_eq = (sa_addr[0 +: RANK_WIDTH] == sa_addr[ADDR_WIDTH   +: RANK_WIDTH]) &&
                   (sa_addr[0 +: RANK_WIDTH] == sa_addr[2*ADDR_WIDTH +: RANK_WIDTH]) &&
                   (sa_addr[0 +: RANK_WIDTH] == sa_addr[3*ADDR_WIDTH +: RANK_WIDTH]);

  // Winner selection: lowest-index starved port, else smallest address (lower index on tie).
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves it unassigned and no latch is inferred.
    win_idx   = 2'd0;
    best_addr = '0;
    found     = 1'b0;
    starved   = '0;
    for (int i = 0; i < 4; i++) begin
      starved[i] = elig[i] && (wait_q[i] == WW'(STARVE_LIMIT));
      if (elig[i] && (!found || sa_addr[i*ADDR_WIDTH +: ADDR_WIDTH] < best_addr)) begin
        found     = 1'b1;
        win_idx   = 2'(i);
        best_addr = sa_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
    for (int i = 3; i >= 0; i--) begin
      if (starved[i]) win_idx = 2'(i);
    end
  end

  // Next-state and grant decision for the ARB / UV_GATHER machine.
  always_comb begin
    state_d      = state_q;
    grant_d      = '0;
    uv_cnt_d     = uv_cnt_q;
    uv_pass_d    = uv_pass_q;
    uv_timeout_d = uv_timeout_q;
    case (state_q)
      ARB: begin
        if (!uv_pass_q && |(elig & sa_uv)) begin
          state_d  = UV_GATHER;
          uv_cnt_d = '0;
        end else if (credit_q != '0 && found) begin
          grant_d   = 4'b0001 << win_idx;
          uv_pass_d = 1'b0;
        end
      end
      UV_GATHER: begin
        uv_cnt_d = uv_cnt_q + 1'b1;
        if (sa_request == 4'hF && sa_uv == 4'hF && rank_eq && credit_q != '0) begin
          grant_d = 4'hF;
          state_d = ARB;
        end else if (uv_cnt_q == UW'(UV_TIMEOUT - 1)) begin
          uv_timeout_d = 1'b1;
          uv_pass_d    = 1'b1;
          state_d      = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // Credit accounting: one credit per grant cycle, credit_in returns one, saturate at full.
  always_comb begin
    credit_d     = credit_q;
    credit_err_d = credit_err_q;
    case ({|grant_d, credit_in})
      2'b10: credit_d = credit_q - 1'b1;
      2'b01: begin
        if (credit_q == CW'(CREDIT_DEPTH)) credit_err_d = 1'b1;
        else                               credit_d     = credit_q + 1'b1;
      end
      default: credit_d = credit_q;
    endcase
  end

  // Aging: count while eligible and losing, clear on grant or dropped request.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      wait_d[i] = wait_q[i];
      if (!sa_request[i] || grant_d[i])                       wait_d[i] = '0;
      else if (elig[i] && wait_q[i] != WW'(STARVE_LIMIT))     wait_d[i] = wait_q[i] + 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB;
      grant_q      <= '0;
      credit_q     <= CW'(CREDIT_DEPTH);
      uv_cnt_q     <= '0;
      uv_pass_q    <= 1'b0;
      credit_err_q <= 1'b0;
      uv_timeout_q <= 1'b0;
      // NOTE: the wait counters are control state, not storage, so they are reset like any other flop.
      for (int i = 0; i < 4; i++) wait_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      grant_q      <= grant_d;
      credit_q     <= credit_d;
      uv_cnt_q     <= uv_cnt_d;
      uv_pass_q    <= uv_pass_d;
      credit_err_q <= credit_err_d;
      uv_timeout_q <= uv_timeout_d;
      for (int i = 0; i < 4; i++) wait_q[i] <= wait_d[i];
    end
  end

  assign sa_grant     = grant_q;
  assign credit_count = credit_q;
  assign uv_busy      = (state_q == UV_GATHER);
  assign credit_err   = credit_err_q;
  assign uv_timeout   = uv_timeout_q;

endmodule

// File: tb/tb_router_sa_scheduler.sv
// Scoreboard bench for router_sa_scheduler: the stimulus pushes expected grants,
// and a negedge monitor pops and compares every non-zero sa_grant.
module tb_router_sa_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sa_request;
  logic [31:0] sa_addr;
  logic [3:0]  sa_uv;
  logic        credit_in;
  logic [3:0]  sa_grant;
  logic [2:0]  credit_count;
  logic        uv_busy;
  logic        credit_err;
  logic        uv_timeout;

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] exp_q [$];

  router_sa_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .sa_request   (sa_request),
    .sa_addr      (sa_addr),
    .sa_uv        (sa_uv),
    .credit_in    (credit_in),
    .sa_grant     (sa_grant),
    .credit_count (credit_count),
    .uv_busy      (uv_busy),
    .credit_err   (credit_err),
    .uv_timeout   (uv_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every grant the DUT presents must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && sa_grant != 4'b0000) begin
      if (exp_q.size() == 0) check("unexpected_grant", 32'(sa_grant), 32'h0);
      else                   check("grant", 32'(sa_grant), 32'(exp_q.pop_front()));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; sa_request = '0; sa_uv = '0; credit_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Run until the scoreboard drains; granted requesters drop their request,
  // and in return mode the downstream frees a slot one cycle after each grant.
  task automatic serve(input int budget, input bit ret_credit, input bit hold_req, output int nw_lat);
    int cyc = 0;
    nw_lat = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      @(negedge clk); #1;
      cyc++;
      if (sa_grant[0] && nw_lat == 0) nw_lat = cyc;
      if (!hold_req) sa_request = sa_request & ~sa_grant;
      if (ret_credit) credit_in = |sa_grant;
    end
    if (hold_req) sa_request = '0;
    if (exp_q.size() != 0) begin
      check("serve_timeout", 32'(exp_q.size()), 32'h0);
      exp_q.delete();
    end
    @(negedge clk);
    credit_in = 1'b0;
  endtask

  initial begin
    int lat;
    int busy_cnt;
    rst = 1'b1; sa_request = '0; sa_addr = '0; sa_uv = '0; credit_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_grant",  32'(sa_grant),     32'h0);
    check("rst_credit", 32'(credit_count), 32'd4);
    check("rst_busy",   32'(uv_busy),      32'h0);
    check("rst_cerr",   32'(credit_err),   32'h0);
    check("rst_uvto",   32'(uv_timeout),   32'h0);
    rst = 1'b0;

    // T2: lowest address wins, tie goes to the lower index; all four credits are spent.
    sa_addr = {8'd7, 8'd3, 8'd3, 8'd9};
    exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
    sa_request = 4'b1111;
    serve(20, 1'b0, 1'b0, lat);
    check("t2_credit_empty", 32'(credit_count), 32'd0);

    // T1: asynchronous reset mid-cycle, checked before any clock edge.
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("t1_async_grant",  32'(sa_grant),     32'h0);
    check("t1_async_credit", 32'(credit_count), 32'd4);
    check("t1_async_flags",  32'({uv_busy, credit_err, uv_timeout}), 32'h0);
    @(negedge clk); rst = 1'b0;

    // T3: four single requests use up the credits, and the fifth waits for a returned credit.
    sa_addr = {8'd40, 8'd30, 8'd20, 8'd10};
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(4'b0001 << k);
      sa_request = 4'b0001 << k;
      serve(10, 1'b0, 1'b0, lat);
    end
    sa_request = 4'b0001;
    repeat (6) @(negedge clk);
    check("t3_starved_credit", 32'(credit_count), 32'd0);
    exp_q.push_back(4'b0001);
    credit_in = 1'b1;
    @(negedge clk);
    credit_in = 1'b0;
    check("t3_ret_no_same_cycle", 32'(sa_grant), 32'h0);
    check("t3_ret_credit", 32'(credit_count), 32'd1);
    @(negedge clk);
    check("t3_ret_grant", 32'(sa_grant), 32'h1);
    check("t3_credit_after", 32'(credit_count), 32'd0);
    #1 sa_request = 4'b0010;
    repeat (4) @(negedge clk);
    check("t3_sixth_pending", 32'(credit_count), 32'd0);
    sa_request = '0;
    credit_in = 1'b1;
    repeat (4) @(negedge clk);
    credit_in = 1'b0;
    check("t3_refill", 32'(credit_count), 32'd4);
    check("t3_no_err", 32'(credit_err), 32'h0);
    credit_in = 1'b1;
    @(negedge clk);
    credit_in = 1'b0;
    check("t3_overflow_err", 32'(credit_err), 32'h1);
    check("t3_overflow_cnt", 32'(credit_count), 32'd4);

    // T4: NW holds the highest address; NE/SE alternate until NW and then SW starve.
    do_reset();
    sa_addr = {8'd30, 8'd20, 8'd10, 8'd200};
    for (int k = 0; k < 15; k++) exp_q.push_back((k % 2 == 0) ? 4'b0010 : 4'b0100);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b1000);
    sa_request = 4'b1111;
    serve(40, 1'b1, 1'b1, lat);
    check("t4_nw_within_limit", 32'(lat >= 1 && lat <= 17), 32'h1);
    check("t4_no_cerr", 32'(credit_err), 32'h0);

    // T5: UV arrivals on cycles 0, 3, 4, 8; the merged grant lands on cycle 9.
    do_reset();
    sa_addr = {8'h45, 8'h35, 8'h25, 8'h15};
    sa_uv = 4'hF;
    exp_q.push_back(4'b1111);
    for (int c = 0; c <= 9; c++) begin
      check($sformatf("t5_busy_c%0d", c), 32'(uv_busy), 32'(c >= 1 && c <= 8));
      case (c)
        0: sa_request[0] = 1'b1;
        3: sa_request[1] = 1'b1;
        4: sa_request[2] = 1'b1;
        8: sa_request[3] = 1'b1;
        9: sa_request = '0;
        default: ;
      endcase
      @(negedge clk);
    end
    check("t5_one_credit", 32'(credit_count), 32'd3);
    check("t5_queue_empty", 32'(exp_q.size()), 32'h0);

    // T6: only three UV requesters -> timeout, one normal win, then re-gather.
    do_reset();
    sa_addr = {8'h45, 8'h35, 8'h25, 8'h15};
    sa_uv = 4'hF;
    sa_request = 4'b0111;
    busy_cnt = 0;
    for (int c = 0; c < 400 && !uv_timeout; c++) begin
      @(negedge clk);
      if (uv_busy) busy_cnt++;
    end
    check("t6_timeout_flag", 32'(uv_timeout), 32'h1);
    check("t6_busy_cycles", 32'(busy_cnt), 32'd255);
    check("t6_back_to_arb", 32'(uv_busy), 32'h0);
    exp_q.push_back(4'b0001);
    serve(5, 1'b0, 1'b0, lat);
    check("t6_regather", 32'(uv_busy), 32'h1);
    check("t6_timeout_sticky", 32'(uv_timeout), 32'h1);
    sa_request = '0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
